// File: rtl/z88_blink_pkg.sv
// Shared definitions for the Blink RTC/timer block.
//   - I/O port addresses decoded by the timer
//   - TSTA / TMK bit positions
//   - default prescaler division (5 ms tick at 9.83 MHz)
package z88_blink_pkg;

    // I/O ports (ca[7:0]). TSTA (read) and TMK (write) share B5.
    localparam logic [7:0] PORT_TACK = 8'hB4;
    localparam logic [7:0] PORT_TMK  = 8'hB5;
    localparam logic [7:0] PORT_TSTA = 8'hB5;
    localparam logic [7:0] PORT_TIM0 = 8'hD0;
    localparam logic [7:0] PORT_TIM1 = 8'hD1;
    localparam logic [7:0] PORT_TIM2 = 8'hD2;
    localparam logic [7:0] PORT_TIM3 = 8'hD3;
    localparam logic [7:0] PORT_TIM4 = 8'hD4;

    // TSTA / TMK bit indices
    localparam int TSTA_TICK = 0;
    localparam int TSTA_SEC  = 1;
    localparam int TSTA_MIN  = 2;

    localparam int CLK_DIV_DEFAULT = 49152;

endpackage

// File: rtl/z88_mod_counter.sv
// Modulo-MOD up counter with synchronous clear.
//   mck  : clock
//   rin  : asynchronous active-high reset
//   inc  : count enable
//   clr  : synchronous clear (dominates inc)
//   q    : current count, 0..MOD-1
//   wrap : combinational, high when this inc takes q from MOD-1 back to 0
module z88_mod_counter #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         mck,
    input  logic         rin,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = inc && (q == LAST);

    always_ff @(posedge mck or posedge rin) begin
        if (rin)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= wrap ? '0 : q + 1'b1;
    end

endmodule

// File: rtl/z88_rtc_timer.sv
// Blink real-time clock / timer.
// Prescaler -> tick counter (TIM0) -> second counter (TIM1) -> minute
// counter (TIM2..TIM4), with TSTA status, TMK interrupt mask and a
// coherent multi-byte read of the minute count via a TIM0-triggered snapshot.
//   mck     : master clock
//   rin     : asynchronous active-high reset
//   restim  : holds prescaler and counters at 0 while high
//   reg_wr  : single-cycle write strobe (addr/wdata valid)
//   reg_rd  : single-cycle read strobe (addr valid)
//   addr    : I/O port
//   wdata   : write data
//   rdata   : registered read data, held until the next decoded read
//   rd_hit  : 1-cycle pulse after a read of one of our ports
//   tsta    : status {min, sec, tick}
//   rtc_int : interrupt request, |(tsta & tmk)
module z88_rtc_timer
    import z88_blink_pkg::*;
#(
    parameter int CLK_DIV       = CLK_DIV_DEFAULT,
    parameter int TICKS_PER_SEC = 200,
    parameter int SECS_PER_MIN  = 60,
    parameter int MIN_W         = 21
) (
    input  logic       mck,
    input  logic       rin,
    input  logic       restim,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rd_hit,
    output logic [2:0] tsta,
    output logic       rtc_int
);

    localparam int PW  = (CLK_DIV > 1)       ? $clog2(CLK_DIV)       : 1;
    localparam int T0W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int T1W = (SECS_PER_MIN > 1)  ? $clog2(SECS_PER_MIN)  : 1;

    logic [PW-1:0]    presc_q_unused;
    logic             tick;
    logic [T0W-1:0]   tim0;
    logic             tim0_wrap;
    logic [T1W-1:0]   tim1;
    logic             tim1_wrap;
    logic [MIN_W-1:0] timm;
    logic [T1W-1:0]   sh_tim1;
    logic [MIN_W-1:0] sh_timm;
    logic [2:0]       tmk;
    logic [2:0]       tsta_set;
    logic [2:0]       tsta_clr;
    logic             rd_dec;
    logic [7:0]       rd_val;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[7:3];

    // restim both freezes (inc=0) and zeroes (clr=1) the chain, so no wrap
    // and hence no status event can fire while it is held.
    z88_mod_counter #(.MOD(CLK_DIV), .W(PW)) u_presc (
        .mck (mck), .rin (rin), .inc (!restim), .clr (restim),
        .q   (presc_q_unused), .wrap (tick)
    );

    z88_mod_counter #(.MOD(TICKS_PER_SEC), .W(T0W)) u_tim0 (
        .mck (mck), .rin (rin), .inc (tick), .clr (restim),
        .q   (tim0), .wrap (tim0_wrap)
    );

    z88_mod_counter #(.MOD(SECS_PER_MIN), .W(T1W)) u_tim1 (
        .mck (mck), .rin (rin), .inc (tim0_wrap), .clr (restim),
        .q   (tim1), .wrap (tim1_wrap)
    );

    // Minute counter wraps silently at 2^MIN_W.
    always_ff @(posedge mck or posedge rin) begin
        if (rin)
            timm <= '0;
        else if (restim)
            timm <= '0;
        else if (tim1_wrap)
            timm <= timm + 1'b1;
    end

    always_comb begin
        tsta_set            = '0;
        tsta_set[TSTA_TICK] = tick;
        tsta_set[TSTA_SEC]  = tim0_wrap;
        tsta_set[TSTA_MIN]  = tim1_wrap;
        tsta_clr            = (reg_wr && addr == PORT_TACK) ? wdata[2:0] : 3'b000;
    end

    // Set is ORed in after the clear so a same-cycle acknowledge never
    // swallows a fresh event.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            tsta <= '0;
            tmk  <= '0;
        end else begin
            tsta <= (tsta & ~tsta_clr) | tsta_set;
            if (reg_wr && addr == PORT_TMK)
                tmk <= wdata[2:0];
        end
    end

    assign rtc_int = |(tsta & tmk);

    always_comb begin
        rd_dec = 1'b1;
        rd_val = '0;
        case (addr)
            PORT_TSTA: rd_val = 8'(tsta);
            PORT_TIM0: rd_val = 8'(tim0);
            PORT_TIM1: rd_val = 8'(sh_tim1);
            PORT_TIM2: rd_val = sh_timm[7:0];
            PORT_TIM3: rd_val = 8'(sh_timm >> 8);
            PORT_TIM4: rd_val = 8'(sh_timm >> 16);
            default:   rd_dec = 1'b0;
        endcase
    end

    // Reading TIM0 freezes TIM1..TIM4 so the following byte reads all come
    // from the same instant, even if the counters carry in between.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            rdata   <= '0;
            rd_hit  <= 1'b0;
            sh_tim1 <= '0;
            sh_timm <= '0;
        end else begin
            rd_hit <= reg_rd && rd_dec;
            if (reg_rd && rd_dec)
                rdata <= rd_val;
            if (reg_rd && addr == PORT_TIM0) begin
                sh_tim1 <= tim1;
                sh_timm <= timm;
            end
        end
    end

endmodule

// File: tb/tb_z88_rtc_timer.sv
// Self-checking bench for z88_rtc_timer (CLK_DIV=4, TICKS_PER_SEC=3,
// SECS_PER_MIN=2, MIN_W=18). Read results go through a scoreboard queue
// checked by a monitor one cycle after each read strobe.
module tb_z88_rtc_timer;

    localparam int CLK_DIV = 4;
    localparam int TPS     = 3;
    localparam int SPM     = 2;
    localparam int MIN_W   = 18;

    logic       mck    = 1'b0;
    logic       rin    = 1'b1;
    logic       restim = 1'b0;
    logic       reg_wr = 1'b0;
    logic       reg_rd = 1'b0;
    logic [7:0] addr   = 8'h00;
    logic [7:0] wdata  = 8'h00;
    logic [7:0] rdata;
    logic       rd_hit;
    logic [2:0] tsta;
    logic       rtc_int;

    always #5 mck = ~mck;

    z88_rtc_timer #(
        .CLK_DIV(CLK_DIV), .TICKS_PER_SEC(TPS), .SECS_PER_MIN(SPM), .MIN_W(MIN_W)
    ) dut (
        .mck(mck), .rin(rin), .restim(restim), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rd_hit(rd_hit),
        .tsta(tsta), .rtc_int(rtc_int)
    );

    int checks = 0;
    int fails  = 0;

    // Active edges since the counters were last zeroed; expected counter
    // values are derived arithmetically from this.
    int act;
    always @(posedge mck or posedge rin) begin
        if (rin)         act <= 0;
        else if (restim) act <= 0;
        else             act <= act + 1;
    end

    function automatic int f_t0(int a); return (a / CLK_DIV) % TPS; endfunction
    function automatic int f_t1(int a); return ((a / CLK_DIV) / TPS) % SPM; endfunction
    function automatic int f_tm(int a); return ((a / CLK_DIV) / (TPS * SPM)) % (1 << MIN_W); endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    typedef struct { logic hit; logic [7:0] data; } rd_exp_t;
    rd_exp_t    sb[$];
    rd_exp_t    mon_e;
    logic [7:0] last_data = 8'h00;

    always @(posedge mck) begin
        if (reg_rd) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_underflow: read result with nothing expected (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("rd_hit", rd_hit, mon_e.hit);
                check("rdata", rdata, mon_e.data);
            end
        end else begin
            #1;
            check("rd_hit_idle", rd_hit, 1'b0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge mck);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic hit, input logic [7:0] d);
        rd_exp_t e;
        e.hit  = hit;
        e.data = hit ? d : last_data;
        if (hit) last_data = d;
        sb.push_back(e);
        reg_rd = 1'b1;
        addr   = a;
        step(1);
        reg_rd = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        reg_wr = 1'b1;
        addr   = a;
        wdata  = d;
        step(1);
        reg_wr = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] a;
        logic [7:0] d;
        int         wt;
        logic [2:0] exp_tsta;
        logic       exp_int;
        logic       hit;
        logic [7:0] rdv;
    } vec_t;

    vec_t vt[17];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         snap_t1;
        int         snap_tm;
        logic [7:0] t0v;

        //          wr  rd  addr   wdata  wt  tsta    irq hit rdata
        vt[0]  = '{1'b0,1'b0,8'h00,8'h00, 3, 3'b001,1'b0,1'b0,8'h00}; // first tick, edge 4
        vt[1]  = '{1'b0,1'b0,8'h00,8'h00, 7, 3'b011,1'b0,1'b0,8'h00}; // edge 12: second
        vt[2]  = '{1'b0,1'b0,8'h00,8'h00,11, 3'b111,1'b0,1'b0,8'h00}; // edge 24: minute
        vt[3]  = '{1'b1,1'b0,8'hB5,8'h02, 0, 3'b111,1'b1,1'b0,8'h00}; // TMK=sec
        vt[4]  = '{1'b1,1'b0,8'hB4,8'h01, 0, 3'b110,1'b1,1'b0,8'h00}; // ack tick
        vt[5]  = '{1'b1,1'b0,8'hB4,8'h07, 0, 3'b000,1'b0,1'b0,8'h00}; // ack all
        vt[6]  = '{1'b0,1'b1,8'hB5,8'h00, 0, 3'b001,1'b0,1'b1,8'h00}; // read TSTA on tick edge
        vt[7]  = '{1'b0,1'b1,8'hB5,8'h00, 0, 3'b001,1'b0,1'b1,8'h01};
        vt[8]  = '{1'b0,1'b0,8'h00,8'h00, 1, 3'b001,1'b0,1'b0,8'h00};
        vt[9]  = '{1'b1,1'b0,8'hB4,8'h01, 0, 3'b001,1'b0,1'b0,8'h00}; // ack on tick: set wins
        vt[10] = '{1'b1,1'b0,8'hB4,8'h01, 0, 3'b000,1'b0,1'b0,8'h00};
        vt[11] = '{1'b1,1'b0,8'hB5,8'h07, 1, 3'b000,1'b0,1'b0,8'h00}; // TMK=all
        vt[12] = '{1'b1,1'b0,8'hB4,8'h02, 0, 3'b011,1'b1,1'b0,8'h00}; // ack sec on sec wrap
        vt[13] = '{1'b0,1'b1,8'hB5,8'h00, 0, 3'b011,1'b1,1'b1,8'h03};
        vt[14] = '{1'b0,1'b1,8'h80,8'h00, 0, 3'b011,1'b1,1'b0,8'h00}; // foreign port
        vt[15] = '{1'b0,1'b1,8'hB4,8'h00, 0, 3'b011,1'b1,1'b0,8'h00}; // TACK is write-only
        vt[16] = '{1'b0,1'b1,8'hD1,8'h00, 0, 3'b011,1'b1,1'b1,8'h00}; // shadow still 0

        // Reset state
        step(2);
        check("rst_tsta", tsta, 3'b000);
        check("rst_int", rtc_int, 1'b0);
        check("rst_rd_hit", rd_hit, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        rin = 1'b0;

        // Counting, status, mask, acknowledge
        for (int i = 0; i < 17; i++) begin
            if (vt[i].rd)      do_read(vt[i].a, vt[i].hit, vt[i].rdv);
            else if (vt[i].wr) do_write(vt[i].a, vt[i].d);
            else               step(1);
            if (vt[i].wt > 0) step(vt[i].wt);
            check($sformatf("vec%0d_tsta", i), tsta, vt[i].exp_tsta);
            check($sformatf("vec%0d_int", i), rtc_int, vt[i].exp_int);
        end

        // Snapshot coherence across the 0xFF -> 0x100 minute roll
        step(6140 - act);
        do_read(8'hD0, 1'b1, 8'h02);
        step(6150 - act);
        do_read(8'hD1, 1'b1, 8'h01);
        do_read(8'hD2, 1'b1, 8'hFF);
        do_read(8'hD3, 1'b1, 8'h00);
        do_read(8'hD4, 1'b1, 8'h00);
        t0v     = 8'(f_t0(act));
        snap_t1 = f_t1(act);
        snap_tm = f_tm(act);
        do_read(8'hD0, 1'b1, t0v);
        do_read(8'hD1, 1'b1, 8'(snap_t1));
        do_read(8'hD2, 1'b1, 8'(snap_tm));
        do_read(8'hD3, 1'b1, 8'(snap_tm >> 8));
        do_read(8'hD4, 1'b1, 8'(snap_tm >> 16));

        // restim hold
        restim = 1'b1;
        step(1);
        do_write(8'hB4, 8'h07);
        do_read(8'hD0, 1'b1, 8'h00);
        do_read(8'hD2, 1'b1, 8'h00);
        step(6);
        check("restim_tsta", tsta, 3'b000);
        check("restim_int", rtc_int, 1'b0);
        restim = 1'b0;
        step(3);
        check("restim_rel_pre", tsta, 3'b000);
        step(1);
        check("restim_rel_tick", tsta, 3'b001);
        step(20);
        check("pre_rst_tsta", tsta, 3'b111);
        check("pre_rst_int", rtc_int, 1'b1);

        // Asynchronous reset between edges
        #3 rin = 1'b1;
        #1;
        check("async_tsta", tsta, 3'b000);
        check("async_int", rtc_int, 1'b0);
        check("async_rdata", rdata, 8'h00);
        last_data = 8'h00;
        #2 rin = 1'b0;
        step(3);
        check("rst_rel_pre", tsta, 3'b000);
        step(1);
        check("rst_rel_tick", tsta, 3'b001);
        check("rst_rel_int", rtc_int, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
